// File: rtl/rng_bit_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : rng_bit_deserializer
//  Description : Serial raw-entropy bit stream to WIDTH-bit parallel words,
//                with optional von Neumann debiasing and a valid/ready
//                word handoff to the downstream conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rng_bit_deserializer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             vn_en,
   input  logic             bit_in,
   input  logic             bit_vld,
   output logic [WIDTH-1:0] word_out,
   output logic             word_vld,
   input  logic             word_rdy,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             ovf,
   input  logic             ovf_clr
);

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_word;
   logic [WIDTH-1:0] w_word_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_ovf;
   logic             w_ovf_nxt;
   logic             r_pair_full;
   logic             w_pair_full_nxt;
   logic             r_pair_bit;
   logic             w_pair_bit_nxt;
   logic             r_vn_prev;
   logic             w_take;
   logic             w_vn_chg;
   logic             w_emit;
   logic             w_ebit;

   // Debiasing front end: decide whether a bit is emitted this cycle and what
   // the pair register holds next. A stored half-pair is discarded whenever
   // collection pauses or the debias mode flips, so it never pairs with a
   // bit sampled under different conditions.
   always_comb begin
      w_take          = en & bit_vld;
      w_vn_chg        = vn_en ^ r_vn_prev;
      w_emit          = 1'b0;
      w_ebit          = 1'b0;
      w_pair_full_nxt = r_pair_full & en & ~w_vn_chg;
      w_pair_bit_nxt  = r_pair_bit;
      if (w_take) begin
         if (!vn_en) begin
            w_emit          = 1'b1;
            w_ebit          = bit_in;
            w_pair_full_nxt = 1'b0;
         end else if (w_pair_full_nxt) begin
            // 01 -> 0, 10 -> 1 (first bit of the pair); 00/11 emit nothing
            w_emit          = r_pair_bit ^ bit_in;
            w_ebit          = r_pair_bit;
            w_pair_full_nxt = 1'b0;
         end else begin
            w_pair_full_nxt = 1'b1;
            w_pair_bit_nxt  = bit_in;
         end
      end
   end

   // Word assembly FSM: next state, word contents, bit count and overflow.
   always_comb begin
      w_state_nxt = r_state;
      w_word_nxt  = r_word;
      w_cnt_nxt   = r_cnt;
      w_ovf_nxt   = r_ovf & ~ovf_clr;
      case (r_state)
         COLLECT: begin
            if (w_emit) begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (r_cnt == CNT_W'(i)) begin
                     w_word_nxt[i] = w_ebit;
                  end
               end
               w_cnt_nxt = r_cnt + c_one;
               if (r_cnt == c_last_idx) begin
                  w_state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (word_rdy) begin
               // A bit arriving on the handshake cycle starts the next word
               w_state_nxt = COLLECT;
               w_cnt_nxt   = w_emit ? c_one : '0;
               if (w_emit) begin
                  w_word_nxt[0] = w_ebit;
               end
            end else if (w_emit) begin
               w_ovf_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = COLLECT;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= COLLECT;
         r_word      <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_pair_full <= 1'b0;
         r_pair_bit  <= 1'b0;
         r_vn_prev   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_word      <= w_word_nxt;
         r_cnt       <= w_cnt_nxt;
         r_ovf       <= w_ovf_nxt;
         r_pair_full <= w_pair_full_nxt;
         r_pair_bit  <= w_pair_bit_nxt;
         r_vn_prev   <= vn_en;
      end
   end

   assign word_out = r_word;
   assign word_vld = (r_state == HOLD);
   assign bit_cnt  = r_cnt;
   assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rng_bit_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rng_bit_deserializer
//  Description : Self-checking bench for rng_bit_deserializer (WIDTH=8).
//                Directed stimulus pushes expected words into a queue; a
//                monitor pops and compares on every word handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rng_bit_deserializer;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic             vn_en;
   logic             bit_in;
   logic             bit_vld;
   logic [WIDTH-1:0] word_out;
   logic             word_vld;
   logic             word_rdy;
   logic [CNT_W-1:0] bit_cnt;
   logic             ovf;
   logic             ovf_clr;

   int               n_vec;
   int               n_fail;
   logic [WIDTH-1:0] exp_q[$];

   rng_bit_deserializer #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .vn_en    (vn_en),
      .bit_in   (bit_in),
      .bit_vld  (bit_vld),
      .word_out (word_out),
      .word_vld (word_vld),
      .word_rdy (word_rdy),
      .bit_cnt  (bit_cnt),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present one input cycle; return just after the edge that consumed it.
   task automatic drive(input logic v, input logic b);
      bit_vld = v;
      bit_in  = b;
      @(posedge clk);
      #1;
      bit_vld = 1'b0;
   endtask

   task automatic pair(input logic a, input logic b);
      drive(1'b1, a);
      drive(1'b1, b);
   endtask

   task automatic feed_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) drive(1'b1, v[i]);
   endtask

   // Scoreboard monitor: compare each handed-off word with the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && word_vld && word_rdy) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_word: got %0h expected none", word_out);
            end else begin
               chk("word_out", 64'(word_out), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] v55;
      v55      = 8'h55;
      n_vec    = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      en       = 1'b1;
      vn_en    = 1'b0;
      bit_in   = 1'b0;
      bit_vld  = 1'b0;
      word_rdy = 1'b1;
      ovf_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_word", 64'(word_out), 64'h0);
      chk("rst_vld",  64'(word_vld), 64'h0);
      chk("rst_cnt",  64'(bit_cnt),  64'h0);
      chk("rst_ovf",  64'(ovf),      64'h0);
      rst_n = 1'b1;
      drive(1'b0, 1'b0);

      // Raw pass-through word: 1,0,1,1,0,0,1,0 -> 8'h4D
      exp_q.push_back(8'h4D);
      feed_byte(8'h4D);
      chk("t1_vld", 64'(word_vld), 64'h1);
      chk("t1_cnt_full", 64'(bit_cnt), 64'd8);
      drive(1'b0, 1'b0);
      chk("t1_vld_drop", 64'(word_vld), 64'h0);
      chk("t1_cnt_zero", 64'(bit_cnt), 64'd0);
      chk("t1_ovf", 64'(ovf), 64'h0);

      // Von Neumann: pairs 01,10,00,11,10 emit 0,1,1 per group -> 8'hB6
      vn_en = 1'b1;
      drive(1'b0, 1'b0);
      exp_q.push_back(8'hB6);
      pair(0, 1); pair(1, 0);
      chk("t2_cnt_a", 64'(bit_cnt), 64'd2);
      pair(0, 0); pair(1, 1);
      chk("t2_cnt_same", 64'(bit_cnt), 64'd2);
      pair(1, 0);
      chk("t2_cnt_b", 64'(bit_cnt), 64'd3);
      pair(0, 1); pair(1, 0); pair(0, 0); pair(1, 1); pair(1, 0);
      pair(0, 1); pair(1, 0);
      chk("t2_vld", 64'(word_vld), 64'h1);
      drive(1'b0, 1'b0);
      chk("t2_cnt_zero", 64'(bit_cnt), 64'd0);

      // Overflow while held, sticky clear, then handshake
      vn_en    = 1'b0;
      word_rdy = 1'b0;
      exp_q.push_back(8'hA5);
      feed_byte(8'hA5);
      chk("t3_vld", 64'(word_vld), 64'h1);
      drive(1'b1, 1'b1); drive(1'b1, 1'b1); drive(1'b1, 1'b1);
      chk("t3_word_frozen", 64'(word_out), 64'hA5);
      chk("t3_cnt_full", 64'(bit_cnt), 64'd8);
      chk("t3_ovf_set", 64'(ovf), 64'h1);
      ovf_clr = 1'b1;
      drive(1'b0, 1'b0);
      ovf_clr = 1'b0;
      chk("t3_ovf_clr", 64'(ovf), 64'h0);
      word_rdy = 1'b1;
      drive(1'b0, 1'b0);
      chk("t3_vld_drop", 64'(word_vld), 64'h0);
      chk("t3_cnt_zero", 64'(bit_cnt), 64'd0);

      // Bit arriving in the handshake cycle starts the next word
      word_rdy = 1'b0;
      exp_q.push_back(8'h3C);
      feed_byte(8'h3C);
      word_rdy = 1'b1;
      exp_q.push_back(8'h55);
      drive(1'b1, 1'b1);
      chk("t4_vld", 64'(word_vld), 64'h0);
      chk("t4_cnt", 64'(bit_cnt), 64'd1);
      chk("t4_bit0", 64'(word_out[0]), 64'h1);
      chk("t4_ovf", 64'(ovf), 64'h0);
      for (int i = 1; i < 8; i++) drive(1'b1, v55[i]);
      drive(1'b0, 1'b0);
      chk("t4_cnt_zero", 64'(bit_cnt), 64'd0);

      // Half-pair discarded by en=0, then by a vn_en toggle
      vn_en = 1'b1;
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      en = 1'b0;
      drive(1'b1, 1'b1); drive(1'b1, 1'b1);
      en = 1'b1;
      pair(1, 0);
      chk("t5_en_cnt", 64'(bit_cnt), 64'd1);
      chk("t5_en_bit", 64'(word_out[0]), 64'h1);
      drive(1'b1, 1'b0);
      vn_en = 1'b0;
      drive(1'b0, 1'b0);
      vn_en = 1'b1;
      drive(1'b0, 1'b0);
      pair(1, 0);
      chk("t5_vn_cnt", 64'(bit_cnt), 64'd2);
      chk("t5_vn_bit", 64'(word_out[1]), 64'h1);

      // Asynchronous reset while holding a word with ovf set
      vn_en    = 1'b0;
      word_rdy = 1'b0;
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
      chk("t6_ovf_pre", 64'(ovf), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_vld",  64'(word_vld), 64'h0);
      chk("t6_rst_cnt",  64'(bit_cnt),  64'h0);
      chk("t6_rst_word", 64'(word_out), 64'h0);
      chk("t6_rst_ovf",  64'(ovf),      64'h0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      word_rdy = 1'b1;
      exp_q.push_back(8'hC6);
      feed_byte(8'hC6);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rng_bit_deserializer.md
Name: rng_bit_deserializer

Overview:
- Reverse direction of the chiplib mux cells: takes the single serial raw-entropy bit stream that the source-select mux tree produces and fans it out into parallel WIDTH-bit words.
- Optional von Neumann debiasing is applied before assembly.
- Hands completed words to the downstream conditioner/register interface over a valid/ready handshake.
- Sits between the sampled mux output and the post-processing logic of the RNG subsystem.

Parameters:
- WIDTH, 32, output word width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH)+1, derived width of the bit counter; do not override.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
- en  input  1  collection enable.
- vn_en  input  1  1 = von Neumann debiasing on; 0 = raw bits passed through.
- bit_in  input  1  sampled entropy bit from the mux tree.
- bit_vld  input  1  bit_in is valid this cycle; no backpressure toward the source.
- word_out  output  WIDTH  assembled word; word_out[0] holds the first bit emitted.
- word_vld  output  1  word_out is complete and stable.
- word_rdy  input  1  consumer accepts the word.
- bit_cnt  output  CNT_W  number of emitted bits in the current partial word.
- ovf  output  1  sticky flag: an emitted bit was dropped because a full word was still held.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset values: word_out=0, word_vld=0, bit_cnt=0, ovf=0, state=COLLECT, pair register empty.
- Input sampling: a raw bit is taken only when en=1 and bit_vld=1. Otherwise no state changes, except as listed below.
- Emitted bit, vn_en=0: every taken raw bit is emitted the same cycle.
- Emitted bit, vn_en=1: raw bits are processed in pairs.
  - The first bit of a pair is stored; the second bit completes the pair.
  - Pair 01 emits 0; pair 10 emits 1, i.e. the first bit is emitted.
  - Pairs 00 and 11 emit nothing. After any completed pair, the pair register is empty.
- Pair register clears, without emitting, when en=0, when vn_en changes value, or when rst_n is asserted.
- en=0 retains the partial word and bit_cnt.
- State COLLECT:
  - An emitted bit is written to word_out[bit_cnt] and bit_cnt increments.
  - If this is bit WIDTH-1: go to HOLD, set word_vld=1 on the next cycle, and bit_cnt reads WIDTH.
- State HOLD:
  - word_out is frozen and word_vld=1.
  - Any emitted bit while word_vld=1 and word_rdy=0 is dropped and sets ovf.
  - Handshake (word_vld & word_rdy): return to COLLECT next cycle with word_vld=0 and bit_cnt=0.
  - If an emitted bit occurs in the handshake cycle, it is not dropped. It becomes word_out[0] of the next word and bit_cnt=1 next cycle. ovf is not set.
- word_out bits above bit_cnt in a partial word hold stale data; the consumer uses word_out only while word_vld=1.
- Latency:
  - vn_en=0: the WIDTH-th accepted bit at edge N gives word_vld=1 after edge N.
  - vn_en=1: the completing second bit of the pair at edge N gives word_vld=1 after edge N.
- word_rdy while word_vld=0 has no effect.
- ovf: set-priority over ovf_clr when both occur in the same cycle. Otherwise ovf_clr clears it on the next edge.
- Reset mid-word or mid-HOLD: immediate clear to reset values. A held word is lost and no handshake is issued.
- Arithmetic: bit_cnt is unsigned and never exceeds WIDTH; no wrap-around. Emitted bit count per word is exactly WIDTH.

Test Plan:
- WIDTH=8, vn_en=0, en=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, word_rdy=1 -> word_vld high for 1 cycle with word_out=8'h4D, bit_cnt returns to 0, ovf=0.
- vn_en=1, raw pairs 01,10,00,11,10 repeated until 8 bits are emitted -> only 01/10 pairs contribute (emits 0,1,1,...), word_out matches a reference model, and 00/11 pairs never change bit_cnt.
- Word held with word_rdy=0, then 3 more valid bits (vn_en=0) -> word_out unchanged, ovf=1; ovf_clr pulse -> ovf=0; word_rdy=1 -> handshake, next word starts at bit_cnt=0.
- Handshake cycle coincident with a valid bit=1 (vn_en=0) -> next cycle word_vld=0, bit_cnt=1, word_out[0]=1, ovf stays 0.
- vn_en=1: first bit of a pair taken, then en=0 for 2 cycles, then pair 10 -> stale first bit discarded, emits 1, bit_cnt advances by exactly 1. Repeat with a vn_en toggle mid-pair -> same pair clear.
- rst_n asserted asynchronously mid-HOLD (between edges) -> word_vld, bit_cnt, word_out and ovf go to 0 immediately. After release, 8 fresh bits produce a correct new word.
